nn_infer_sequencer: RTL and testbench
=====================================

// Module: nn_infer_sequencer
// PURPOSE
//  Sequences one two-layer MLP inference over the shared SRAM/MAC/sigmoid datapath.
//  Layer 1:
//   - For each hidden pass, streams input and weight addresses to MAC1.
//   - Pulses mac1_start on the last element, then waits for mac1_done.
//   - Logs the pass index as the hidden-activation write address.
//  Layer 2:
//   - Same scheme over the hidden activations into MAC2.
//  Sits above top's SRAM/MAC instances and replaces manual bench address driving.
// PARAMETERS
//  N_IN        784    layer-1 vector length (inputs per pass)
//  N_L1_PASSES 200    layer-1 passes; also the layer-2 vector length
//  N_L2_PASSES 1      layer-2 passes
//  L1_WA_W     18     layer-1 weight address width; N_IN*N_L1_PASSES <= 2**L1_WA_W
//  L1_XA_W     10     input address width; N_IN <= 2**L1_XA_W
//  H_A_W       8      hidden address width; N_L1_PASSES <= 2**H_A_W
//  L2_WA_W     12     layer-2 weight address width; N_L1_PASSES*N_L2_PASSES <= 2**L2_WA_W
//  TIMEOUT     1023   max cycles spent waiting for a MAC done
// PORTS
//  clk        in   1        rising-edge clock
//  reset      in   1        asynchronous, active-high reset
//  start      in   1        one-cycle request to begin an inference; ignored unless IDLE/DONE/ERROR
//  abort      in   1        synchronous abort; returns to IDLE next cycle
//  busy       out  1        high in any L1_*/L2_* state
//  done       out  1        one-cycle pulse on entering DONE
//  err        out  1        sticky timeout flag; cleared by start or reset
//  address_1  out  L1_WA_W  layer-1 weight address
//  address_3  out  L1_XA_W  input-image address
//  mac1_start out  1        MAC1 accumulate-complete strobe
//  mac1_done  in   1        MAC1 result ready (level or pulse)
//  h_wr_en    out  1        hidden activation write strobe
//  h_wr_addr  out  H_A_W    hidden activation index
//  address_2  out  L2_WA_W  layer-2 weight address
//  address_4  out  H_A_W    hidden-activation read address
//  mac2_start out  1        MAC2 accumulate-complete strobe
//  mac2_done  in   1        MAC2 result ready
// BEHAVIOUR
//  Reset: state=IDLE; all outputs and counters 0.
//  States: IDLE, L1_STREAM, L1_WAIT, L2_STREAM, L2_WAIT, DONE, ERROR.
//  IDLE/DONE/ERROR + start -> L1_STREAM; clears err; zeroes j, pass and address registers.
//  L1_STREAM, one element per cycle:
//   - address_3=j; address_1=pass*N_IN+j, kept as a running counter (no multiplier).
//   - mac1_start=1 only in the cycle j==N_IN-1; then -> L1_WAIT.
//  L1_WAIT:
//   - On mac1_done: one-cycle h_wr_en with h_wr_addr=pass; pass++.
//   - If pass was N_L1_PASSES-1 -> L2_STREAM, else -> L1_STREAM with j=0.
//  L2_STREAM:
//   - address_4=k; address_2=p2*N_L1_PASSES+k.
//   - mac2_start in the cycle k==N_L1_PASSES-1; then -> L2_WAIT.
//  L2_WAIT:
//   - On mac2_done: p2++.
//   - Last pass -> DONE with a one-cycle done pulse, else -> L2_STREAM.
//  Done inputs are sampled only in the *_WAIT states; done seen during *_STREAM is ignored.
//  Wait counter:
//   - Clears on WAIT entry.
//   - Reaching TIMEOUT without done -> ERROR: err=1, busy=0.
//  abort has priority over all transitions except reset; start while busy is ignored.
//  Outputs are registered; strobes are exactly one cycle; addresses hold their value in WAIT states.
//  Per-pass latency: N_IN stream cycles + done latency + 1.
//  Reset or abort mid-run discards all progress; no partial done.
// TESTING
//  - reset, then start with mac1_done returned 3 cycles after mac1_start: address_3 runs 0..783; mac1_start in the address_3=783 cycle; pass 1 begins with address_1=784.
//  - Full run (N_L1_PASSES=200, N_L2_PASSES=1): 200 h_wr_en pulses with h_wr_addr 0..199; address_2 ends at 199; exactly one done pulse; busy falls with DONE.
//  - mac1_done asserted during L1_STREAM: ignored; pass does not advance until done arrives in L1_WAIT.
//  - mac2_done withheld: err=1 exactly TIMEOUT cycles after L2_WAIT entry; state ERROR; a new start clears err.
//  - abort at pass 5, j=100: next cycle IDLE, busy=0, address outputs 0; a new start restarts at address_1=0.
//  - start pulsed mid-run, and reset asserted mid-stream: start has no effect; reset gives asynchronous zero outputs.

Source files
------------

// File: rtl/nn_infer_sequencer.sv
// nn_infer_sequencer: drives SRAM addresses and MAC strobes through one two-layer MLP inference.
module nn_infer_sequencer #(
  parameter int N_IN        = 784,
  parameter int N_L1_PASSES = 200,
  parameter int N_L2_PASSES = 1,
  parameter int L1_WA_W     = 18,
  parameter int L1_XA_W     = 10,
  parameter int H_A_W       = 8,
  parameter int L2_WA_W     = 12,
  parameter int TIMEOUT     = 1023
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [L1_WA_W-1:0] address_1,
  output logic [L1_XA_W-1:0] address_3,
  output logic               mac1_start,
  input  logic               mac1_done,
  output logic               h_wr_en,
  output logic [H_A_W-1:0]   h_wr_addr,
  output logic [L2_WA_W-1:0] address_2,
  output logic [H_A_W-1:0]   address_4,
  output logic               mac2_start,
  input  logic               mac2_done
);
  localparam int P2_W = $clog2(N_L2_PASSES + 1);
  localparam int W_W  = $clog2(TIMEOUT + 1);
  localparam logic [L1_XA_W-1:0] J_LAST  = L1_XA_W'(N_IN - 1);
  localparam logic [H_A_W-1:0]   P_LAST  = H_A_W'(N_L1_PASSES - 1);
  localparam logic [P2_W-1:0]    P2_LAST = P2_W'(N_L2_PASSES - 1);
  localparam logic [W_W-1:0]     W_LAST  = W_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, L1_STREAM, L1_WAIT, L2_STREAM, L2_WAIT, DONE, ERROR} state_t;

  state_t               state_q, state_d;
  logic [L1_XA_W-1:0]   j_q, j_d;
  logic [H_A_W-1:0]     pass_q, pass_d, k_q, k_d, hwa_q, hwa_d;
  logic [P2_W-1:0]      p2_q, p2_d;
  logic [L1_WA_W-1:0]   a1_q, a1_d;
  logic [L2_WA_W-1:0]   a2_q, a2_d;
  logic [W_W-1:0]       w_q, w_d;
  logic                 m1_q, m1_d, m2_q, m2_d, hwe_q, hwe_d, done_q, done_d, err_q, err_d;

  // Weight addresses are running counters: they advance with every streamed element
  // and continue from their last value at the start of the next pass.
  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    pass_d  = pass_q;
    k_d     = k_q;
    hwa_d   = hwa_q;
    p2_d    = p2_q;
    a1_d    = a1_q;
    a2_d    = a2_q;
    w_d     = w_q;
    err_d   = err_q;
    m1_d    = 1'b0;
    m2_d    = 1'b0;
    hwe_d   = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE, DONE, ERROR: if (start) begin
        state_d = L1_STREAM;
        err_d   = 1'b0;
        j_d     = '0;
        pass_d  = '0;
        k_d     = '0;
        hwa_d   = '0;
        p2_d    = '0;
        a1_d    = '0;
        a2_d    = '0;
        m1_d    = (N_IN == 1);
      end
      L1_STREAM: if (j_q == J_LAST) begin
        state_d = L1_WAIT;
        w_d     = '0;
      end else begin
        j_d  = j_q + 1'b1;
        a1_d = a1_q + 1'b1;
        m1_d = (j_q + 1'b1 == J_LAST);
      end
      L1_WAIT: if (mac1_done) begin
        hwe_d  = 1'b1;
        hwa_d  = pass_q;
        pass_d = pass_q + 1'b1;
        if (pass_q == P_LAST) begin
          state_d = L2_STREAM;
          m2_d    = (N_L1_PASSES == 1);
        end else begin
          state_d = L1_STREAM;
          j_d     = '0;
          a1_d    = a1_q + 1'b1;
          m1_d    = (N_IN == 1);
        end
      end else if (w_q == W_LAST) begin
        state_d = ERROR;
        err_d   = 1'b1;
      end else w_d = w_q + 1'b1;
      L2_STREAM: if (k_q == P_LAST) begin
        state_d = L2_WAIT;
        w_d     = '0;
      end else begin
        k_d  = k_q + 1'b1;
        a2_d = a2_q + 1'b1;
        m2_d = (k_q + 1'b1 == P_LAST);
      end
      L2_WAIT: if (mac2_done) begin
        p2_d = p2_q + 1'b1;
        if (p2_q == P2_LAST) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d = L2_STREAM;
          k_d     = '0;
          a2_d    = a2_q + 1'b1;
          m2_d    = (N_L1_PASSES == 1);
        end
      end else if (w_q == W_LAST) begin
        state_d = ERROR;
        err_d   = 1'b1;
      end else w_d = w_q + 1'b1;
      default: state_d = IDLE;
    endcase
    // Abort discards all progress but leaves a sticky error visible.
    if (abort) begin
      state_d = IDLE;
      j_d     = '0;
      pass_d  = '0;
      k_d     = '0;
      hwa_d   = '0;
      p2_d    = '0;
      a1_d    = '0;
      a2_d    = '0;
      w_d     = '0;
      m1_d    = 1'b0;
      m2_d    = 1'b0;
      hwe_d   = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      j_q     <= '0;
      pass_q  <= '0;
      k_q     <= '0;
      hwa_q   <= '0;
      p2_q    <= '0;
      a1_q    <= '0;
      a2_q    <= '0;
      w_q     <= '0;
      err_q   <= 1'b0;
      m1_q    <= 1'b0;
      m2_q    <= 1'b0;
      hwe_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      pass_q  <= pass_d;
      k_q     <= k_d;
      hwa_q   <= hwa_d;
      p2_q    <= p2_d;
      a1_q    <= a1_d;
      a2_q    <= a2_d;
      w_q     <= w_d;
      err_q   <= err_d;
      m1_q    <= m1_d;
      m2_q    <= m2_d;
      hwe_q   <= hwe_d;
      done_q  <= done_d;
    end
  end

  assign busy       = state_q inside {L1_STREAM, L1_WAIT, L2_STREAM, L2_WAIT};
  assign done       = done_q;
  assign err        = err_q;
  assign address_1  = a1_q;
  assign address_3  = j_q;
  assign mac1_start = m1_q;
  assign h_wr_en    = hwe_q;
  assign h_wr_addr  = hwa_q;
  assign address_2  = a2_q;
  assign address_4  = k_q;
  assign mac2_start = m2_q;
endmodule

// File: tb/tb_nn_infer_sequencer.sv
// tb_nn_infer_sequencer: cycle-level reference model plus directed scenarios for the inference sequencer.
module tb_nn_infer_sequencer;
  localparam int NI = 120, NP = 8, NP2 = 2, TO = 50;
  localparam int P_IDLE = 0, P_L1S = 1, P_L1W = 2, P_L2S = 3, P_L2W = 4, P_DONE = 5, P_ERR = 6;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0;
  logic resp1 = 1'b0, spur1 = 1'b0, resp2 = 1'b0, d2_en = 1'b1;
  logic mac1_done, mac2_done;
  logic busy, done, err, mac1_start, h_wr_en, mac2_start;
  logic [17:0] address_1;
  logic [9:0]  address_3;
  logic [7:0]  h_wr_addr, address_4;
  logic [11:0] address_2;

  assign mac1_done = resp1 | spur1;
  assign mac2_done = resp2;

  nn_infer_sequencer #(.N_IN(NI), .N_L1_PASSES(NP), .N_L2_PASSES(NP2), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .busy(busy), .done(done), .err(err),
    .address_1(address_1), .address_3(address_3), .mac1_start(mac1_start), .mac1_done(mac1_done),
    .h_wr_en(h_wr_en), .h_wr_addr(h_wr_addr), .address_2(address_2), .address_4(address_4),
    .mac2_start(mac2_start), .mac2_done(mac2_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int h_cnt = 0, last_hwa = 0, done_cnt = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase plus element/pass indices; addresses are derived by multiplication.
  int ph = P_IDLE, mj = 0, mpass = 0, map = 0, mk = 0, mp2 = 0, map2 = 0, mw = 0, mhwa = 0;
  bit merr = 0, mh = 0, mdn = 0;

  task automatic m_clear();
    mj = 0; mpass = 0; map = 0; mk = 0; mp2 = 0; map2 = 0; mhwa = 0; mw = 0;
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    mh = 0;
    mdn = 0;
    if (reset) begin
      ph = P_IDLE;
      merr = 0;
      m_clear();
    end else if (abort) begin
      ph = P_IDLE;
      m_clear();
    end else case (ph)
      P_IDLE, P_DONE, P_ERR: if (start) begin
        ph = P_L1S;
        merr = 0;
        m_clear();
      end
      P_L1S: if (mj == NI - 1) begin ph = P_L1W; mw = 0; end else mj++;
      P_L1W: if (mac1_done) begin
        mh = 1;
        mhwa = mpass;
        mpass++;
        if (mpass == NP) begin ph = P_L2S; mk = 0; end
        else begin ph = P_L1S; mj = 0; map = mpass; end
      end else begin
        mw++;
        if (mw == TO) begin ph = P_ERR; merr = 1; end
      end
      P_L2S: if (mk == NP - 1) begin ph = P_L2W; mw = 0; end else mk++;
      P_L2W: if (mac2_done) begin
        mp2++;
        if (mp2 == NP2) begin ph = P_DONE; mdn = 1; end
        else begin ph = P_L2S; mk = 0; map2 = mp2; end
      end else begin
        mw++;
        if (mw == TO) begin ph = P_ERR; merr = 1; end
      end
      default: ph = P_IDLE;
    endcase
  end

  initial forever begin
    @(negedge clk);
    chk("busy", int'(busy), int'(ph >= P_L1S && ph <= P_L2W));
    chk("address_3", int'(address_3), mj);
    chk("address_1", int'(address_1), map * NI + mj);
    chk("mac1_start", int'(mac1_start), int'(ph == P_L1S && mj == NI - 1));
    chk("h_wr_en", int'(h_wr_en), int'(mh));
    chk("h_wr_addr", int'(h_wr_addr), mhwa);
    chk("address_4", int'(address_4), mk);
    chk("address_2", int'(address_2), map2 * NP + mk);
    chk("mac2_start", int'(mac2_start), int'(ph == P_L2S && mk == NP - 1));
    chk("done", int'(done), int'(mdn));
    chk("err", int'(err), int'(merr));
  end

  initial forever begin
    @(posedge clk);
    #2;
    if (h_wr_en) begin h_cnt++; last_hwa = int'(h_wr_addr); end
    if (done) done_cnt++;
  end

  // MAC responders: result ready three cycles after the start strobe.
  initial forever begin
    @(posedge clk);
    #1;
    if (mac1_start) begin
      repeat (2) @(posedge clk);
      #1 resp1 = 1'b1;
      @(posedge clk);
      #1 resp1 = 1'b0;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (mac2_start && d2_en) begin
      repeat (2) @(posedge clk);
      #1 resp2 = 1'b1;
      @(posedge clk);
      #1 resp2 = 1'b0;
    end
  end

  function automatic bit sig(input int w);
    case (w)
      0: return mac1_start;
      1: return h_wr_en;
      2: return done;
      3: return mac2_start;
      4: return address_1 == 18'd700;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input string nm, input int w, input int lim);
    int n = 0;
    while (!sig(w) && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (!sig(w)) chk({nm, "_wait_expired"}, 0, 1);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_address_1", int'(address_1), 0);
    chk("reset_err", int'(err), 0);
    reset = 1'b0;
    pulse_start();
    chk("first_address_3", int'(address_3), 0);
    chk("run_busy", int'(busy), 1);
    wait_for("mac1_start_p0", 0, 300);
    chk("p0_last_address_3", int'(address_3), 119);
    chk("p0_last_address_1", int'(address_1), 119);
    wait_for("h_wr_p0", 1, 50);
    chk("p0_h_wr_addr", int'(h_wr_addr), 0);
    chk("p1_address_1", int'(address_1), 120);
    chk("p1_address_3", int'(address_3), 0);
    @(negedge clk);
    wait_for("mac1_start_p1", 0, 300);
    wait_for("h_wr_p1", 1, 50);
    spur1 = 1'b1;
    repeat (5) @(negedge clk);
    spur1 = 1'b0;
    wait_for("mac1_start_p2", 0, 300);
    chk("stream_done_ignored", h_cnt, 2);
    chk("p2_last_address_1", int'(address_1), 359);
    repeat (3) @(negedge clk);
    pulse_start();
    wait_for("done_run1", 2, 3000);
    chk("h_wr_count", h_cnt, NP);
    chk("last_h_wr_addr", last_hwa, NP - 1);
    chk("final_address_2", int'(address_2), 15);
    chk("final_address_1", int'(address_1), 959);
    @(negedge clk);
    chk("busy_after_done", int'(busy), 0);
    chk("done_single_cycle", int'(done), 0);
    chk("done_count", done_cnt, 1);

    d2_en = 1'b0;
    pulse_start();
    wait_for("mac2_start_to", 3, 2000);
    @(negedge clk);
    n = 0;
    while (!err && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_cycles", n, TO);
    chk("error_busy", int'(busy), 0);
    d2_en = 1'b1;
    h_cnt = 0;
    pulse_start();
    chk("start_clears_err", int'(err), 0);
    chk("restart_busy", int'(busy), 1);

    wait_for("pass5_j100", 4, 2000);
    chk("abort_point_address_3", int'(address_3), 100);
    chk("abort_point_passes", h_cnt, 5);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_address_1", int'(address_1), 0);
    chk("abort_address_3", int'(address_3), 0);
    pulse_start();
    chk("restart_address_1", int'(address_1), 0);
    @(negedge clk);
    chk("restart_address_1_next", int'(address_1), 1);

    repeat (20) @(negedge clk);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("async_reset_busy", int'(busy), 0);
    chk("async_reset_address_1", int'(address_1), 0);
    chk("async_reset_address_3", int'(address_3), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got no summary expected one");
    $fatal(1);
  end
endmodule
